pipe_queue_elastic: RTL and testbench

Parametrised successor to the fixed-length register delay queue used in the register-fetch control path. It is a LENGTH-stage delay line with a per-stage valid bit. It supports whole-pipe freeze, synchronous flush, and an output hold; during a hold, upstream stages keep advancing into empty slots, so bubbles collapse and no data is lost. It also provides an occupancy count and a debug tap of any stage.

---
 rtl/pipe_queue_elastic.sv | 112 +++++++++++
 tb/tb_pipe_queue_elastic.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_queue_elastic.sv
// Elastic LENGTH-stage delay line with per-stage valid bits, freeze, flush,
// output hold with bubble collapse, occupancy count and a debug stage tap.
module pipe_queue_elastic #(
  parameter int                   LENGTH      = 5,
  parameter int                   REG_WIDTH   = 32,
  parameter logic [REG_WIDTH-1:0] DEFAULT_VAL = '0,
  localparam int                  CW          = $clog2(LENGTH + 1)
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [REG_WIDTH-1:0] data_in,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 freeze,
  input  logic                 flush,
  input  logic                 out_hold,
  output logic [REG_WIDTH-1:0] data_out,
  output logic                 out_valid,
  output logic [CW-1:0]        count,
  input  logic [CW-1:0]        tap_sel,
  output logic [REG_WIDTH-1:0] tap_data,
  output logic                 tap_valid
);

  // Index 0 is stage 1 (input side), index LENGTH-1 is the output stage.
  logic [LENGTH-1:0]    valid_q, valid_d;
  logic [REG_WIDTH-1:0] data_q [LENGTH];
  logic [REG_WIDTH-1:0] data_d [LENGTH];
  logic [CW-1:0]        count_q, count_d;

  logic [LENGTH-1:0]    move;
  logic                 accept;
  logic                 take;

  // A stage advances when its successor is empty or advancing itself, so the
  // chain is resolved from the output side backwards.
  always_comb begin
    logic downstream_move;
    // NOTE: every variable written here gets a default first, so no latch is inferred.
    move                 = '0;
    move[LENGTH-1]       = valid_q[LENGTH-1] & ~out_hold & ~freeze;
    downstream_move      = move[LENGTH-1];
    for (int i = LENGTH - 2; i >= 0; i--) begin
      move[i]         = valid_q[i] & ~freeze & (~valid_q[i+1] | downstream_move);
      downstream_move = move[i];
    end
  end

  assign in_ready = ~freeze & ~flush & (~valid_q[0] | move[0]);
  assign accept   = in_valid & in_ready;
  assign take     = move[LENGTH-1];

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    count_d = count_q + CW'(accept) - CW'(take);

    if (accept) begin
      valid_d[0] = 1'b1;
      data_d[0]  = data_in;
    end else if (move[0]) begin
      valid_d[0] = 1'b0;
      data_d[0]  = DEFAULT_VAL;
    end

    for (int i = 1; i < LENGTH; i++) begin
      if (move[i-1]) begin
        valid_d[i] = 1'b1;
        data_d[i]  = data_q[i-1];
      end else if (move[i]) begin
        valid_d[i] = 1'b0;
        data_d[i]  = DEFAULT_VAL;
      end
    end

    if (flush) begin
      valid_d = '0;
      count_d = '0;
      for (int i = 0; i < LENGTH; i++) data_d[i] = DEFAULT_VAL;
    end
  end

  // NOTE: the data array is reset too, because empty stages must read DEFAULT_VAL.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      count_q <= '0;
      for (int i = 0; i < LENGTH; i++) data_q[i] <= DEFAULT_VAL;
    end else begin
      // NOTE: non-blocking updates so every stage samples pre-edge neighbours.
      valid_q <= valid_d;
      count_q <= count_d;
      for (int i = 0; i < LENGTH; i++) data_q[i] <= data_d[i];
    end
  end

  assign data_out  = data_q[LENGTH-1];
  assign out_valid = valid_q[LENGTH-1];
  assign count     = count_q;

  always_comb begin
    tap_valid = 1'b0;
    tap_data  = DEFAULT_VAL;
    for (int i = 0; i < LENGTH; i++) begin
      if (tap_sel == CW'(i + 1)) begin
        tap_valid = valid_q[i];
        tap_data  = data_q[i];
      end
    end
  end

endmodule

// File: tb/tb_pipe_queue_elastic.sv
// Directed, table-driven bench for pipe_queue_elastic (LENGTH = 5) with a
// non-zero DEFAULT_VAL so empty-stage values are distinguishable from data.
module tb_pipe_queue_elastic;

  localparam int          LENGTH = 5;
  localparam int          W      = 32;
  localparam int          CW     = $clog2(LENGTH + 1);
  localparam logic [W-1:0] DV    = 32'hDEAD_BEEF;

  logic          clock;
  logic          reset_n;
  logic [W-1:0]  data_in;
  logic          in_valid;
  logic          in_ready;
  logic          freeze;
  logic          flush;
  logic          out_hold;
  logic [W-1:0]  data_out;
  logic          out_valid;
  logic [CW-1:0] count;
  logic [CW-1:0] tap_sel;
  logic [W-1:0]  tap_data;
  logic          tap_valid;

  pipe_queue_elastic #(
    .LENGTH     (LENGTH),
    .REG_WIDTH  (W),
    .DEFAULT_VAL(DV)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .data_in  (data_in),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .freeze   (freeze),
    .flush    (flush),
    .out_hold (out_hold),
    .data_out (data_out),
    .out_valid(out_valid),
    .count    (count),
    .tap_sel  (tap_sel),
    .tap_data (tap_data),
    .tap_valid(tap_valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic          iv;
    logic [W-1:0]  d;
    logic          hold;
    logic          frz;
    logic          fl;
    logic          exp_ready;   // sampled before the edge
    logic          exp_ov;      // sampled after the edge
    logic [W-1:0]  exp_do;
    logic [CW-1:0] exp_cnt;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   row    = 0;

  function automatic vec_t v(input logic iv, input logic [W-1:0] d,
                             input logic hold, input logic frz, input logic fl,
                             input logic er, input logic eov,
                             input logic [W-1:0] edo, input int ec);
    vec_t x;
    x.iv = iv; x.d = d; x.hold = hold; x.frz = frz; x.fl = fl;
    x.exp_ready = er; x.exp_ov = eov; x.exp_do = edo; x.exp_cnt = CW'(ec);
    return x;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic run_vecs(input string seg);
    foreach (vecs[k]) begin
      @(negedge clock);
      in_valid = vecs[k].iv;
      data_in  = vecs[k].d;
      out_hold = vecs[k].hold;
      freeze   = vecs[k].frz;
      flush    = vecs[k].fl;
      #1;
      check($sformatf("%s[%0d] in_ready", seg, k), W'(in_ready), W'(vecs[k].exp_ready));
      @(posedge clock);
      #1;
      check($sformatf("%s[%0d] out_valid", seg, k), W'(out_valid), W'(vecs[k].exp_ov));
      check($sformatf("%s[%0d] data_out", seg, k), data_out, vecs[k].exp_do);
      check($sformatf("%s[%0d] count", seg, k), W'(count), W'(vecs[k].exp_cnt));
      row++;
    end
    vecs.delete();
  endtask

  task automatic check_tap(input string name, input int sel, input logic ev, input logic [W-1:0] ed);
    tap_sel = CW'(sel);
    #1;
    check({name, " tap_valid"}, W'(tap_valid), W'(ev));
    check({name, " tap_data"}, tap_data, ed);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n  = 1'b0;
    data_in  = '0;
    in_valid = 1'b0;
    freeze   = 1'b0;
    flush    = 1'b0;
    out_hold = 1'b0;
    tap_sel  = CW'(1);

    #12;
    check("reset out_valid", W'(out_valid), 0);
    check("reset data_out", data_out, DV);
    check("reset count", W'(count), 0);
    check("reset in_ready", W'(in_ready), 1);
    check_tap("reset stage1", 1, 1'b0, DV);
    reset_n = 1'b1;

    // Stream 0x11..0x17: first word out after the 5th capture edge.
    vecs.push_back(v(1, 32'h11, 0, 0, 0, 1, 0, DV,    1));
    vecs.push_back(v(1, 32'h12, 0, 0, 0, 1, 0, DV,    2));
    vecs.push_back(v(1, 32'h13, 0, 0, 0, 1, 0, DV,    3));
    vecs.push_back(v(1, 32'h14, 0, 0, 0, 1, 0, DV,    4));
    vecs.push_back(v(1, 32'h15, 0, 0, 0, 1, 1, 32'h11, 5));
    vecs.push_back(v(1, 32'h16, 0, 0, 0, 1, 1, 32'h12, 5));
    vecs.push_back(v(1, 32'h17, 0, 0, 0, 1, 1, 32'h13, 5));
    vecs.push_back(v(0, 32'h55, 0, 0, 0, 1, 1, 32'h14, 4));
    vecs.push_back(v(0, 32'h55, 0, 0, 0, 1, 1, 32'h15, 3));
    vecs.push_back(v(0, 32'h55, 0, 0, 0, 1, 1, 32'h16, 2));
    vecs.push_back(v(0, 32'h55, 0, 0, 0, 1, 1, 32'h17, 1));
    vecs.push_back(v(0, 32'h55, 0, 0, 0, 1, 0, DV,    0));
    run_vecs("stream");

    // Fill, hold full for 3 cycles with a pending word, then drain.
    vecs.push_back(v(1, 32'hA0, 0, 0, 0, 1, 0, DV,    1));
    vecs.push_back(v(1, 32'hA1, 0, 0, 0, 1, 0, DV,    2));
    vecs.push_back(v(1, 32'hA2, 0, 0, 0, 1, 0, DV,    3));
    vecs.push_back(v(1, 32'hA3, 0, 0, 0, 1, 0, DV,    4));
    vecs.push_back(v(1, 32'hA4, 0, 0, 0, 1, 1, 32'hA0, 5));
    for (int k = 0; k < 3; k++)
      vecs.push_back(v(1, 32'hEE, 1, 0, 0, 0, 1, 32'hA0, 5));
    vecs.push_back(v(0, 32'h55, 0, 0, 0, 1, 1, 32'hA1, 4));
    vecs.push_back(v(0, 32'h55, 0, 0, 0, 1, 1, 32'hA2, 3));
    vecs.push_back(v(0, 32'h55, 0, 0, 0, 1, 1, 32'hA3, 2));
    vecs.push_back(v(0, 32'h55, 0, 0, 0, 1, 1, 32'hA4, 1));
    vecs.push_back(v(0, 32'h55, 0, 0, 0, 1, 0, DV,    0));
    run_vecs("hold");

    // Words separated by bubbles, then hold once 0x01 is at the output.
    vecs.push_back(v(1, 32'h01, 0, 0, 0, 1, 0, DV,    1));
    vecs.push_back(v(0, 32'h55, 0, 0, 0, 1, 0, DV,    1));
    vecs.push_back(v(1, 32'h02, 0, 0, 0, 1, 0, DV,    2));
    vecs.push_back(v(0, 32'h55, 0, 0, 0, 1, 0, DV,    2));
    vecs.push_back(v(1, 32'h03, 0, 0, 0, 1, 1, 32'h01, 3));
    vecs.push_back(v(0, 32'h55, 1, 0, 0, 1, 1, 32'h01, 3));
    vecs.push_back(v(0, 32'h55, 1, 0, 0, 1, 1, 32'h01, 3));
    run_vecs("bubble");
    check_tap("collapse stage5", 5, 1'b1, 32'h01);
    check_tap("collapse stage4", 4, 1'b1, 32'h02);
    check_tap("collapse stage3", 3, 1'b1, 32'h03);
    check_tap("collapse stage2", 2, 1'b0, DV);
    check_tap("collapse stage1", 1, 1'b0, DV);

    // flush together with freeze on a partially filled pipe; the word is dropped.
    vecs.push_back(v(1, 32'h77, 1, 1, 1, 0, 0, DV, 0));
    vecs.push_back(v(0, 32'h55, 0, 0, 0, 1, 0, DV, 0));
    run_vecs("flush");
    check_tap("post-flush stage1", 1, 1'b0, DV);

    // Two-cycle freeze mid-stream, then a freeze while the output is valid.
    vecs.push_back(v(1, 32'h21, 0, 0, 0, 1, 0, DV,    1));
    vecs.push_back(v(1, 32'h22, 0, 0, 0, 1, 0, DV,    2));
    vecs.push_back(v(1, 32'h99, 0, 1, 0, 0, 0, DV,    2));
    vecs.push_back(v(1, 32'h99, 0, 1, 0, 0, 0, DV,    2));
    vecs.push_back(v(1, 32'h23, 0, 0, 0, 1, 0, DV,    3));
    vecs.push_back(v(1, 32'h24, 0, 0, 0, 1, 0, DV,    4));
    vecs.push_back(v(1, 32'h25, 0, 0, 0, 1, 1, 32'h21, 5));
    vecs.push_back(v(0, 32'h55, 0, 1, 0, 0, 1, 32'h21, 5));
    vecs.push_back(v(0, 32'h55, 0, 0, 0, 1, 1, 32'h22, 4));
    vecs.push_back(v(0, 32'h55, 0, 0, 0, 1, 1, 32'h23, 3));
    vecs.push_back(v(0, 32'h55, 0, 0, 0, 1, 1, 32'h24, 2));
    vecs.push_back(v(0, 32'h55, 0, 0, 0, 1, 1, 32'h25, 1));
    vecs.push_back(v(0, 32'h55, 0, 0, 0, 1, 0, DV,    0));
    run_vecs("freeze");

    // Fill, then assert reset between edges.
    vecs.push_back(v(1, 32'hB0, 0, 0, 0, 1, 0, DV,    1));
    vecs.push_back(v(1, 32'hB1, 0, 0, 0, 1, 0, DV,    2));
    vecs.push_back(v(1, 32'hB2, 0, 0, 0, 1, 0, DV,    3));
    vecs.push_back(v(1, 32'hB3, 0, 0, 0, 1, 0, DV,    4));
    vecs.push_back(v(1, 32'hB4, 0, 0, 0, 1, 1, 32'hB0, 5));
    run_vecs("fill");
    in_valid = 1'b0;
    check_tap("full stage3", 3, 1'b1, 32'hB2);
    #1;
    reset_n = 1'b0;
    #1;
    check("async reset out_valid", W'(out_valid), 0);
    check("async reset data_out", data_out, DV);
    check("async reset count", W'(count), 0);
    check_tap("async reset stage3", 3, 1'b0, DV);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    check("post-reset in_ready", W'(in_ready), 1);

    // Tap range boundaries with one valid word in stage 1.
    in_valid = 1'b1;
    data_in  = 32'hC5;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    check("single count", W'(count), 1);
    check_tap("tap sel1", 1, 1'b1, 32'hC5);
    check_tap("tap sel2", 2, 1'b0, DV);
    check_tap("tap sel0", 0, 1'b0, DV);
    check_tap("tap sel7", 7, 1'b0, DV);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
